tetris_title_renderer: RTL and testbench

Pipelined, parametrised renderer for the scaled, colour-animated "TETRIS" title banner in the right-hand margin of the VGA frame. It takes the per-pixel draw coordinate stream from the VGA controller and returns, a fixed 3 cycles later, a lit flag and a 12-bit RGB colour for the colour mapper. Letter colours rotate through a palette once every `ANIM_FRAMES` frames.

---
 rtl/tetris_pkg.sv | 53 +++++
 rtl/tetris_glyph_rom.sv | 28 ++
 rtl/tetris_title_renderer.sv | 158 +++++++++++++++
 tb/tb_tetris_title_renderer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types, palette and glyph bitmaps for the TETRIS title banner.
// Rows are MSB-leftmost; rows 0-1 and 12-15 are blank.
package tetris_pkg;

    typedef logic [11:0] color_t;

    localparam int T_GLYPHS = 6;
    localparam int T_GW     = 10;
    localparam int T_GH     = 16;

    localparam color_t PALETTE [8] = '{
        12'hf00, 12'hf70, 12'hff0, 12'h7f0,
        12'h0df, 12'he5f, 12'hfff, 12'h888
    };

    localparam logic [T_GW-1:0] GLYPHS [T_GLYPHS][T_GH] = '{
        // T
        '{10'b0000000000, 10'b0000000000, 10'b1111111111, 10'b1111111111,
          10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0000110000,
          10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0000110000,
          10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000},
        // E
        '{10'b0000000000, 10'b0000000000, 10'b1111111111, 10'b1111111111,
          10'b1100000000, 10'b1100000000, 10'b1111111100, 10'b1111111100,
          10'b1100000000, 10'b1100000000, 10'b1111111111, 10'b1111111111,
          10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000},
        // T
        '{10'b0000000000, 10'b0000000000, 10'b1111111111, 10'b1111111111,
          10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0000110000,
          10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0000110000,
          10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000},
        // R
        '{10'b0000000000, 10'b0000000000, 10'b1111111100, 10'b1111111100,
          10'b1100000011, 10'b1100000011, 10'b1111111100, 10'b1111111100,
          10'b1100001100, 10'b1100001100, 10'b1100000011, 10'b1100000011,
          10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000},
        // I
        '{10'b0000000000, 10'b0000000000, 10'b1111111111, 10'b1111111111,
          10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0000110000,
          10'b0000110000, 10'b0000110000, 10'b1111111111, 10'b1111111111,
          10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000},
        // S
        '{10'b0000000000, 10'b0000000000, 10'b1111111111, 10'b1111111111,
          10'b1100000000, 10'b1100000000, 10'b1111111111, 10'b1111111111,
          10'b0000000011, 10'b0000000011, 10'b1111111111, 10'b1111111111,
          10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000}
    };

    function automatic int title_width(input int ng, input int gw, input int sc);
        return ng * gw * sc;
    endfunction

endpackage

// File: rtl/tetris_glyph_rom.sv
// Synchronous glyph row ROM addressed by {glyph, row}, 1-cycle latency.
// Glyph codes past the bitmap set read as blank.
module tetris_glyph_rom
    import tetris_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic            Clk,
    input  logic [AW-1:0]   addr,
    output logic [T_GW-1:0] data
);

    localparam int RW = $clog2(T_GH);

    logic [AW-RW-1:0] g;
    logic [RW-1:0]    r;

    assign g = addr[AW-1:RW];
    assign r = addr[RW-1:0];

    always_ff @(posedge Clk) begin
        if (int'(g) < T_GLYPHS)
            data <= GLYPHS[g][r];
        else
            data <= '0;
    end

endmodule

// File: rtl/tetris_title_renderer.sv
// Three-stage renderer for the scaled, colour-cycling TETRIS banner.
// S1: box/address, S2: ROM read + colour index, S3: bit select + palette.
module tetris_title_renderer
    import tetris_pkg::*;
#(
    parameter int     NUM_GLYPHS  = 6,
    parameter int     GLYPH_W     = 10,
    parameter int     GLYPH_H     = 16,
    parameter int     SCALE       = 3,
    parameter int     ORIGIN_X    = 440,
    parameter int     ORIGIN_Y    = 40,
    parameter int     NUM_COLORS  = 6,
    parameter int     ANIM_FRAMES = 30,
    parameter color_t BG_COLOR    = 12'h000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic        anim_en,
    input  logic        pix_valid,
    input  logic [9:0]  drawX,
    input  logic [9:0]  drawY,
    output logic        out_valid,
    output logic        in_title,
    output color_t      color
);

    localparam int BW  = title_width(NUM_GLYPHS, GLYPH_W, SCALE);
    localparam int BH  = GLYPH_H * SCALE;
    localparam int GLW = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1;
    localparam int RW  = $clog2(GLYPH_H);
    localparam int CW  = $clog2(GLYPH_W);
    localparam int FW  = $clog2(ANIM_FRAMES + 1);
    localparam int PW  = 3;

    if (ORIGIN_X + BW > 640) begin : g_chk_w
        $error("title banner exceeds screen width");
    end
    if (ORIGIN_Y + BH > 480) begin : g_chk_h
        $error("title banner exceeds screen height");
    end
    if (SCALE < 1 || SCALE > 4) begin : g_chk_s
        $error("SCALE must be 1..4");
    end
    if (NUM_GLYPHS > T_GLYPHS || GLYPH_W != T_GW || GLYPH_H != T_GH) begin : g_chk_g
        $error("glyph geometry does not match bitmap set");
    end
    if (NUM_COLORS < 1 || NUM_COLORS > 8 || ANIM_FRAMES < 1) begin : g_chk_a
        $error("bad NUM_COLORS or ANIM_FRAMES");
    end

    // 11-bit relative coords: bit 10 set means left of / above the box
    logic [10:0]    rx, ry;
    logic [9:0]     gx, gy;
    logic           box_c;
    logic [GLW-1:0] glyph_c;
    logic [RW-1:0]  row_c;
    logic [CW-1:0]  col_c;

    always_comb begin
        rx      = {1'b0, drawX} - 11'(ORIGIN_X);
        ry      = {1'b0, drawY} - 11'(ORIGIN_Y);
        box_c   = !rx[10] && !ry[10]
                  && (rx[9:0] < 10'(BW)) && (ry[9:0] < 10'(BH));
        gx      = rx[9:0] / 10'(SCALE);
        gy      = ry[9:0] / 10'(SCALE);
        glyph_c = GLW'(gx / 10'(GLYPH_W));
        col_c   = CW'(gx % 10'(GLYPH_W));
        row_c   = RW'(gy);
    end

    logic           v1, box1;
    logic [GLW-1:0] glyph1;
    logic [RW-1:0]  row1;
    logic [CW-1:0]  col1;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            v1     <= 1'b0;
            box1   <= 1'b0;
            glyph1 <= '0;
            row1   <= '0;
            col1   <= '0;
        end else begin
            v1     <= pix_valid;
            box1   <= box_c;
            glyph1 <= glyph_c;
            row1   <= row_c;
            col1   <= col_c;
        end
    end

    logic [GLYPH_W-1:0] rom_data;

    tetris_glyph_rom #(
        .AW (GLW + RW)
    ) u_rom (
        .Clk  (Clk),
        .addr ({glyph1, row1}),
        .data (rom_data)
    );

    logic [FW-1:0] frame_cnt;
    logic [PW-1:0] offset;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_cnt <= '0;
            offset    <= '0;
        end else if (frame_start && anim_en) begin
            if (frame_cnt == FW'(ANIM_FRAMES - 1)) begin
                frame_cnt <= '0;
                offset    <= (offset == PW'(NUM_COLORS - 1)) ? '0 : offset + 1'b1;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    logic [PW-1:0] cidx_c;

    assign cidx_c = PW'((int'(glyph1) + int'(offset)) % NUM_COLORS);

    logic          v2, box2;
    logic [CW-1:0] col2;
    logic [PW-1:0] cidx2;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            v2    <= 1'b0;
            box2  <= 1'b0;
            col2  <= '0;
            cidx2 <= '0;
        end else begin
            v2    <= v1;
            box2  <= box1;
            col2  <= col1;
            cidx2 <= cidx_c;
        end
    end

    logic lit_c;

    assign lit_c = box2 && rom_data[CW'(GLYPH_W - 1) - col2];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            in_title  <= 1'b0;
            color     <= BG_COLOR;
        end else begin
            out_valid <= v2;
            in_title  <= lit_c;
            color     <= lit_c ? PALETTE[cidx2] : BG_COLOR;
        end
    end

endmodule

// File: tb/tb_tetris_title_renderer.sv
// Directed bench for tetris_title_renderer: geometry, glyph bits,
// colour rotation and mid-stream reset flush.
module tb_tetris_title_renderer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_start;
    logic        anim_en;
    logic        pix_valid;
    logic [9:0]  drawX;
    logic [9:0]  drawY;
    logic        out_valid;
    logic        in_title;
    logic [11:0] color;

    int checks   = 0;
    int failures = 0;

    tetris_title_renderer dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .anim_en     (anim_en),
        .pix_valid   (pix_valid),
        .drawX       (drawX),
        .drawY       (drawY),
        .out_valid   (out_valid),
        .in_title    (in_title),
        .color       (color)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // one isolated pixel; outputs appear after the third rising edge
    task automatic probe(input int x, input int y, input logic exp_lit,
                         input logic [11:0] exp_col, input string tag);
        @(negedge Clk);
        pix_valid = 1'b1;
        drawX     = 10'(x);
        drawY     = 10'(y);
        @(negedge Clk);
        pix_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk({tag, "_valid"}, 12'(out_valid), 12'h001);
        chk({tag, "_lit"}, 12'(in_title), 12'(exp_lit));
        chk({tag, "_color"}, color, exp_col);
        @(negedge Clk);
        chk({tag, "_drop"}, 12'(out_valid), 12'h000);
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            @(negedge Clk);
            frame_start = 1'b1;
            @(negedge Clk);
            frame_start = 1'b0;
        end
    endtask

    initial begin
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        anim_en     = 1'b0;
        pix_valid   = 1'b0;
        drawX       = '0;
        drawY       = '0;
        repeat (3) @(negedge Clk);
        chk("rst_valid", 12'(out_valid), 12'h000);
        chk("rst_lit", 12'(in_title), 12'h000);
        chk("rst_color", color, 12'h000);
        Reset_n = 1'b1;

        probe(440, 46, 1'b1, 12'hf00, "t_r2c0");
        probe(439, 46, 1'b0, 12'h000, "left_out");
        probe(620, 46, 1'b0, 12'h000, "right_out");
        probe(619, 46, 1'b1, 12'he5f, "s_r2c9");
        probe(619, 87, 1'b0, 12'h000, "s_r15");
        probe(440, 88, 1'b0, 12'h000, "below_out");
        probe(440, 43, 1'b0, 12'h000, "t_r1");
        probe(470, 46, 1'b1, 12'hf70, "e_r2c0");
        probe(455, 60, 1'b1, 12'hf00, "t_stem");
        probe(446, 60, 1'b0, 12'h000, "t_gap");

        anim_en = 1'b0;
        pulses(30);
        probe(440, 46, 1'b1, 12'hf00, "frozen");

        anim_en = 1'b1;
        pulses(30);
        probe(440, 46, 1'b1, 12'hf70, "anim30");
        pulses(120);
        probe(440, 46, 1'b1, 12'he5f, "anim150");
        pulses(30);
        probe(440, 46, 1'b1, 12'hf00, "anim180_wrap");
        pulses(30);
        probe(440, 46, 1'b1, 12'hf70, "pre_rst_off1");

        // 8 back-to-back pixels, reset sampled at the edge after slot 4
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (k == 3) begin
                chk("stream_pre_valid", 12'(out_valid), 12'h001);
                chk("stream_pre_color", color, 12'hf70);
            end
            if (k >= 5) begin
                chk($sformatf("post_rst_valid%0d", k - 5),
                    12'(out_valid), 12'h000);
            end
            if (k == 5)
                chk("post_rst_color", color, 12'h000);
            Reset_n   = (k == 4) ? 1'b0 : 1'b1;
            pix_valid = 1'b1;
            drawX     = 10'd440;
            drawY     = 10'd46;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            pix_valid = 1'b0;
            chk($sformatf("post_rst_pix%0d_valid", k), 12'(out_valid), 12'h001);
            chk($sformatf("post_rst_pix%0d_color", k), color, 12'hf00);
        end
        @(negedge Clk);
        chk("stream_end_valid", 12'(out_valid), 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
